sdram_mc_fifo_ctrl: RTL

Parametrised multi-channel FIFO-to-SDRAM burst scheduler; successor to the single write/single read FIFO control inside the SDRAM top level. It watches the fill levels of NCH user FIFOs, each configured as write or read, and round-robin arbitrates among channels that can take a full burst. It issues one burst request at a time to the SDRAM controller and keeps a per-channel wrap-around address pointer bounded by min/max address. It sits between the user FIFOs and the SDRAM command controller in the SDRAM clock domain.

---
 rtl/sdram_mc_fifo_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sdram_mc_fifo_ctrl.sv
// Multi-channel FIFO-to-SDRAM burst scheduler: round-robin arbitration over NCH user FIFOs,
// one burst in flight at a time, with a wrap-around address pointer per channel.
module sdram_mc_fifo_ctrl #(
  parameter int NCH        = 4,
  parameter int ADDR_W     = 24,
  parameter int LEN_W      = 10,
  parameter int LVL_W      = 11,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sdram_init_done,
  input  logic [NCH-1:0]        ch_mode,
  input  logic [NCH-1:0]        ch_en,
  input  logic [NCH*LVL_W-1:0]  ch_level,
  input  logic [NCH*ADDR_W-1:0] ch_minaddr,
  input  logic [NCH*ADDR_W-1:0] ch_maxaddr,
  input  logic [NCH*LEN_W-1:0]  ch_len,
  input  logic [NCH-1:0]        ch_load,
  output logic                  sdram_req,
  output logic                  sdram_rw,
  output logic [ADDR_W-1:0]     sdram_addr,
  output logic [LEN_W-1:0]      sdram_len,
  input  logic                  sdram_ack,
  input  logic                  sdram_done,
  output logic [NCH-1:0]        ch_grant,
  output logic [NCH-1:0]        ch_wrap,
  output logic                  busy
);
  // state    | meaning
  // S_IDLE   | no burst in flight; arbitrate among eligible channels
  // S_REQ    | sdram_req high with stable addr/len/rw, waiting for sdram_ack
  // S_BUSY   | burst accepted, waiting for sdram_done
  // S_UPDATE | advance or wrap the owner's pointer, release the grant

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = (LEN_W > LVL_W + 1) ? LEN_W : LVL_W + 1;
  localparam int SW = ADDR_W + 2;
  localparam logic [LVL_W:0] DEPTH_V = (LVL_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY, S_UPDATE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr [NCH];
  logic [NCH-1:0]    load_pend;
  logic [IW-1:0]     rr_last;
  logic [IW-1:0]     owner;

  logic [NCH-1:0]    elig;
  logic              win_found;
  logic [IW-1:0]     win;

  logic [ADDR_W-1:0] own_min;
  logic [ADDR_W-1:0] own_max;
  logic [LEN_W-1:0]  own_len;
  logic [SW-1:0]     nxt;
  logic [SW-1:0]     last;
  logic              wrap_cond;

  // Write channels need a full burst of data, read channels a full burst of free space.
  function automatic logic can_burst(input logic mode, input logic [LVL_W-1:0] lvl,
                                     input logic [LEN_W-1:0] len);
    logic [LVL_W:0] space;
    space = mode ? (DEPTH_V - {1'b0, lvl}) : {1'b0, lvl};
    return CW'(space) >= CW'(len);
  endfunction

  always_comb begin
    elig = '0;
    for (int i = 0; i < NCH; i++) begin
      elig[i] = ch_en[i] && sdram_init_done && !load_pend[i] && !ch_load[i] &&
                (ch_len[i*LEN_W +: LEN_W] != '0) &&
                can_burst(ch_mode[i], ch_level[i*LVL_W +: LVL_W], ch_len[i*LEN_W +: LEN_W]);
    end
  end

  always_comb begin
    win_found = 1'b0;
    win       = '0;
    for (int k = 1; k <= NCH; k++) begin
      if (!win_found && elig[IW'((int'(rr_last) + k) % NCH)]) begin
        win_found = 1'b1;
        win       = IW'((int'(rr_last) + k) % NCH);
      end
    end
  end

  assign own_min   = ch_minaddr[owner*ADDR_W +: ADDR_W];
  assign own_max   = ch_maxaddr[owner*ADDR_W +: ADDR_W];
  assign own_len   = ch_len[owner*LEN_W +: LEN_W];
  // Advance by the burst just done; the next burst must fit entirely below maxaddr.
  assign nxt       = SW'(ptr[owner]) + SW'(sdram_len);
  assign last      = nxt + SW'(own_len) - SW'(1);
  assign wrap_cond = last > SW'(own_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sdram_req  <= 1'b0;
      sdram_rw   <= 1'b0;
      sdram_addr <= '0;
      sdram_len  <= '0;
      ch_grant   <= '0;
      ch_wrap    <= '0;
      busy       <= 1'b0;
      load_pend  <= '0;
      rr_last    <= IW'(NCH - 1);
      owner      <= '0;
      for (int i = 0; i < NCH; i++) ptr[i] <= '0;
    end else begin
      ch_wrap <= '0;
      for (int i = 0; i < NCH; i++) begin
        if (ch_load[i]) begin
          if (state != S_IDLE && owner == IW'(i)) load_pend[i] <= 1'b1;
          else ptr[i] <= ch_minaddr[i*ADDR_W +: ADDR_W];
        end
      end
      case (state)
        S_IDLE: begin
          if (win_found) begin
            state      <= S_REQ;
            sdram_req  <= 1'b1;
            sdram_rw   <= ch_mode[win];
            sdram_addr <= ptr[win];
            sdram_len  <= ch_len[win*LEN_W +: LEN_W];
            ch_grant   <= NCH'(1) << win;
            owner      <= win;
            rr_last    <= win;
            busy       <= 1'b1;
          end
        end
        S_REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state     <= sdram_done ? S_UPDATE : S_BUSY;
          end
        end
        S_BUSY: begin
          if (sdram_done) state <= S_UPDATE;
        end
        S_UPDATE: begin
          // A deferred load wins over the increment and suppresses the wrap pulse.
          if (load_pend[owner] || ch_load[owner]) begin
            ptr[owner] <= own_min;
          end else if (wrap_cond) begin
            ptr[owner]     <= own_min;
            ch_wrap[owner] <= 1'b1;
          end else begin
            ptr[owner] <= nxt[ADDR_W-1:0];
          end
          load_pend[owner] <= 1'b0;
          ch_grant         <= '0;
          busy             <= 1'b0;
          state            <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
